// File: rtl/pag_refill.sv
// Page-table refill sequencer: fetches the page-map word after a PAG miss and writes the PT entry and directory tag.
// Optional macro PAG_REFILL_PARITY_EN: reject acknowledged words whose odd parity is bad.
module pag_refill #(
  parameter int unsigned TIMEOUT  = 63,
  parameter logic        EXEC_OFS = 1'b1
) (
  input  logic         clk,
  input  logic         CROBAR,
  input  logic         refill_req,
  input  logic         abort,
  input  logic         vma_user,
  input  logic [13:26] vma,
  input  logic [14:26] ubr,
  input  logic [14:26] ebr,
  output logic         mem_req,
  output logic [14:35] mem_adr,
  input  logic         mem_ack,
  input  logic [0:35]  mem_data,
  input  logic         mem_par,
  output logic         pgrf_cyc,
  output logic         pt_wr,
  output logic [18:26] pt_adr,
  output logic [0:35]  pt_din,
  output logic         dir_wr,
  output logic [5:0]   dir_din,
  output logic         refill_done,
  output logic         refill_err
);

  typedef enum logic [2:0] {IDLE, ADR, WAIT, WRITE, DONE, ERR} state_t;

  localparam logic [5:0] TimeoutCnt = 6'(TIMEOUT);

  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [14:35]  memAdr_q, memAdr_d;
  logic [18:26]  ptAdr_q, ptAdr_d;
  logic [0:35]   ptDin_q, ptDin_d;
  logic [5:0]    dirDin_q, dirDin_d;
  logic [14:26]  base;
  logic          parityOk;

  // The PT write always covers both halves, so vma[26] never reaches the datapath.
`ifdef PAG_REFILL_PARITY_EN
  assign parityOk = ^{mem_data, mem_par};
  logic unusedBits;
  assign unusedBits = vma[26];
`else
  assign parityOk = 1'b1;
  logic unusedBits;
  assign unusedBits = ^{vma[26], mem_par};
`endif

  assign base = vma_user ? ubr : ebr;

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      memAdr_q <= '0;
      ptAdr_q  <= '0;
      ptDin_q  <= '0;
      dirDin_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      memAdr_q <= memAdr_d;
      ptAdr_q  <= ptAdr_d;
      ptDin_q  <= ptDin_d;
      dirDin_q <= dirDin_d;
    end
  end

  // Abort wins over a coincident ack; a WRITE in progress still completes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    memAdr_d    = memAdr_q;
    ptAdr_d     = ptAdr_q;
    ptDin_d     = ptDin_q;
    dirDin_d    = dirDin_q;
    mem_req     = 1'b0;
    pgrf_cyc    = 1'b0;
    pt_wr       = 1'b0;
    dir_wr      = 1'b0;
    refill_done = 1'b0;
    refill_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (refill_req && !abort) begin
          state_d  = ADR;
          memAdr_d = {base, (vma_user ? ~EXEC_OFS : EXEC_OFS), vma[18:25]};
          ptAdr_d  = {vma[18:25], 1'b0};
          dirDin_d = {vma_user, vma[13:17]};
        end
      end
      ADR: begin
        mem_req  = 1'b1;
        pgrf_cyc = 1'b1;
        cnt_d    = '0;
        state_d  = abort ? IDLE : WAIT;
      end
      WAIT: begin
        mem_req  = 1'b1;
        pgrf_cyc = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          if (parityOk) begin
            ptDin_d = mem_data;
            state_d = WRITE;
          end else begin
            state_d = ERR;
          end
        end else if (cnt_q == TimeoutCnt) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      WRITE: begin
        pgrf_cyc = 1'b1;
        pt_wr    = 1'b1;
        dir_wr   = 1'b1;
        state_d  = abort ? IDLE : DONE;
      end
      DONE: begin
        pgrf_cyc    = 1'b1;
        refill_done = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        refill_err = 1'b1;
        if (!refill_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_adr = memAdr_q;
  assign pt_adr  = ptAdr_q;
  assign pt_din  = ptDin_q;
  assign dir_din = dirDin_q;

endmodule

// File: tb/tb_pag_refill.sv
// Directed testbench for pag_refill: reset, user/exec refills, timeout, parity, abort and back-to-back requests.
module tb_pag_refill;

  logic         clk = 1'b0;
  logic         CROBAR;
  logic         refill_req;
  logic         abort;
  logic         vma_user;
  logic [13:26] vma;
  logic [14:26] ubr;
  logic [14:26] ebr;
  logic         mem_req;
  logic [14:35] mem_adr;
  logic         mem_ack;
  logic [0:35]  mem_data;
  logic         mem_par;
  logic         pgrf_cyc;
  logic         pt_wr;
  logic [18:26] pt_adr;
  logic [0:35]  pt_din;
  logic         dir_wr;
  logic [5:0]   dir_din;
  logic         refill_done;
  logic         refill_err;

  int passCount = 0;
  int checkCount = 0;

  pag_refill dut (
    .clk(clk), .CROBAR(CROBAR), .refill_req(refill_req), .abort(abort),
    .vma_user(vma_user), .vma(vma), .ubr(ubr), .ebr(ebr),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack),
    .mem_data(mem_data), .mem_par(mem_par), .pgrf_cyc(pgrf_cyc),
    .pt_wr(pt_wr), .pt_adr(pt_adr), .pt_din(pt_din), .dir_wr(dir_wr),
    .dir_din(dir_din), .refill_done(refill_done), .refill_err(refill_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    CROBAR = 1'b1;
    tick; tick;
    checkCount++; if (mem_req !== 1'b0) $display("[TB] FAIL rst_mem_req: got %b want 0", mem_req); else passCount++;
    checkCount++; if (pgrf_cyc !== 1'b0) $display("[TB] FAIL rst_pgrf_cyc: got %b want 0", pgrf_cyc); else passCount++;
    checkCount++; if ({pt_wr, dir_wr, refill_done, refill_err} !== 4'b0) $display("[TB] FAIL rst_strobes: got %b want 0000", {pt_wr, dir_wr, refill_done, refill_err}); else passCount++;
    checkCount++; if (mem_adr !== 22'h0) $display("[TB] FAIL rst_mem_adr: got %h want 0", mem_adr); else passCount++;
    checkCount++; if ({pt_adr, pt_din, dir_din} !== 51'h0) $display("[TB] FAIL rst_pt_regs: got %h want 0", {pt_adr, pt_din, dir_din}); else passCount++;
    CROBAR = 1'b0;
    // Now reset again in the middle of WAIT.
    vma_user = 1'b1; vma = {5'h03, 8'h12, 1'b0}; ubr = 13'h0777; ebr = 13'h0001;
    refill_req = 1'b1;
    tick;
    refill_req = 1'b0;
    tick; tick;
    checkCount++; if (mem_req !== 1'b1) $display("[TB] FAIL rst_pre_wait: got %b want 1", mem_req); else passCount++;
    CROBAR = 1'b1;
    tick; tick;
    checkCount++; if ({mem_req, pgrf_cyc, pt_wr, refill_done, refill_err} !== 5'b0) $display("[TB] FAIL rst_mid_wait_outs: got %b want 00000", {mem_req, pgrf_cyc, pt_wr, refill_done, refill_err}); else passCount++;
    checkCount++; if (mem_adr !== 22'h0) $display("[TB] FAIL rst_mid_wait_adr: got %h want 0", mem_adr); else passCount++;
    CROBAR = 1'b0;
    mem_ack = 1'b1; mem_data = 36'o777000777000; mem_par = ~^36'o777000777000;
    tick;
    mem_ack = 1'b0;
    begin
      logic sawWr;
      sawWr = pt_wr;
      for (int i = 0; i < 4; i++) begin tick; sawWr |= pt_wr; end
      checkCount++; if (sawWr !== 1'b0) $display("[TB] FAIL rst_no_pt_wr: got %b want 0", sawWr); else passCount++;
    end
  endtask

  task automatic test_user_refill;
    logic [0:35] data;
    data = 36'o123456654321;
    vma_user = 1'b1; vma = {5'h0B, 8'hA5, 1'b1}; ubr = 13'h0123; ebr = 13'h0456;
    refill_req = 1'b1;
    tick;                               // cycle 1: ADR
    refill_req = 1'b0;
    checkCount++; if (mem_req !== 1'b1) $display("[TB] FAIL user_adr_req: got %b want 1", mem_req); else passCount++;
    checkCount++; if (mem_adr !== {13'h0123, 1'b0, 8'hA5}) $display("[TB] FAIL user_mem_adr: got %h want %h", mem_adr, {13'h0123, 1'b0, 8'hA5}); else passCount++;
    tick;                               // cycle 2: WAIT
    checkCount++; if ({mem_req, pgrf_cyc} !== 2'b11) $display("[TB] FAIL user_wait: got %b want 11", {mem_req, pgrf_cyc}); else passCount++;
    tick; tick;                         // cycle 4: ack
    mem_ack = 1'b1; mem_data = data; mem_par = ~^data;
    tick;                               // cycle 5: WRITE
    mem_ack = 1'b0;
    checkCount++; if ({pt_wr, dir_wr, mem_req} !== 3'b110) $display("[TB] FAIL user_write_strobes: got %b want 110", {pt_wr, dir_wr, mem_req}); else passCount++;
    checkCount++; if (pt_adr !== 9'h14A) $display("[TB] FAIL user_pt_adr: got %h want 14a", pt_adr); else passCount++;
    checkCount++; if (pt_din !== 36'o123456654321) $display("[TB] FAIL user_pt_din: got %o want 123456654321", pt_din); else passCount++;
    checkCount++; if (dir_din !== 6'b101011) $display("[TB] FAIL user_dir_din: got %b want 101011", dir_din); else passCount++;
    tick;                               // cycle 6: DONE
    checkCount++; if ({refill_done, pt_wr, pgrf_cyc} !== 3'b101) $display("[TB] FAIL user_done: got %b want 101", {refill_done, pt_wr, pgrf_cyc}); else passCount++;
    tick;
    checkCount++; if ({refill_done, pgrf_cyc} !== 2'b00) $display("[TB] FAIL user_idle: got %b want 00", {refill_done, pgrf_cyc}); else passCount++;
  endtask

  task automatic test_exec_refill;
    vma_user = 1'b0; vma = {5'h1F, 8'hFF, 1'b0}; ubr = 13'h0123; ebr = 13'h1FFF;
    refill_req = 1'b1;
    tick;                               // cycle 1
    refill_req = 1'b0;
    checkCount++; if (mem_adr !== 22'h3FFFFF) $display("[TB] FAIL exec_mem_adr: got %h want 3fffff", mem_adr); else passCount++;
    checkCount++; if (mem_adr[27] !== 1'b1) $display("[TB] FAIL exec_bit27: got %b want 1", mem_adr[27]); else passCount++;
    tick;                               // cycle 2: immediate ack
    mem_ack = 1'b1; mem_data = 36'o000777000777; mem_par = ~^36'o000777000777;
    tick;                               // cycle 3
    mem_ack = 1'b0;
    checkCount++; if (pt_wr !== 1'b1) $display("[TB] FAIL exec_pt_wr: got %b want 1", pt_wr); else passCount++;
    checkCount++; if (pt_adr !== 9'h1FE) $display("[TB] FAIL exec_pt_adr: got %h want 1fe", pt_adr); else passCount++;
    checkCount++; if (dir_din !== 6'b011111) $display("[TB] FAIL exec_dir_din: got %b want 011111", dir_din); else passCount++;
    tick;                               // cycle 4
    checkCount++; if (refill_done !== 1'b1) $display("[TB] FAIL exec_done_cycle4: got %b want 1", refill_done); else passCount++;
    tick;
  endtask

  task automatic test_ack_in_adr;
    vma_user = 1'b1; vma = {5'h01, 8'h33, 1'b0};
    refill_req = 1'b1;
    tick;                               // ADR
    refill_req = 1'b0;
    mem_ack = 1'b1; mem_data = 36'o1; mem_par = ~^36'o1;
    tick;                               // WAIT, early ack ignored
    mem_ack = 1'b0;
    checkCount++; if ({mem_req, pt_wr} !== 2'b10) $display("[TB] FAIL adr_ack_ignored: got %b want 10", {mem_req, pt_wr}); else passCount++;
    tick;
    checkCount++; if ({mem_req, pt_wr} !== 2'b10) $display("[TB] FAIL adr_ack_still_wait: got %b want 10", {mem_req, pt_wr}); else passCount++;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checkCount++; if ({mem_req, pgrf_cyc} !== 2'b00) $display("[TB] FAIL adr_ack_abort: got %b want 00", {mem_req, pgrf_cyc}); else passCount++;
  endtask

  task automatic test_timeout;
    int n;
    logic sawWr;
    vma_user = 1'b0; vma = {5'h02, 8'h44, 1'b0};
    refill_req = 1'b1;
    tick;                               // ADR
    tick;                               // WAIT entry
    n = 0; sawWr = 1'b0;
    while (n < 200) begin
      tick; n++;
      sawWr |= pt_wr;
      if (refill_err) break;
    end
    checkCount++; if (n !== 64) $display("[TB] FAIL timeout_cycles: got %0d want 64", n); else passCount++;
    checkCount++; if (sawWr !== 1'b0) $display("[TB] FAIL timeout_no_pt_wr: got %b want 0", sawWr); else passCount++;
    checkCount++; if ({mem_req, pgrf_cyc} !== 2'b00) $display("[TB] FAIL timeout_err_outs: got %b want 00", {mem_req, pgrf_cyc}); else passCount++;
    abort = 1'b1;
    tick; tick;
    abort = 1'b0;
    checkCount++; if (refill_err !== 1'b1) $display("[TB] FAIL timeout_err_held: got %b want 1", refill_err); else passCount++;
    refill_req = 1'b0;
    tick;
    checkCount++; if (refill_err !== 1'b0) $display("[TB] FAIL timeout_err_exit: got %b want 0", refill_err); else passCount++;
    tick;
    checkCount++; if (mem_req !== 1'b0) $display("[TB] FAIL timeout_idle: got %b want 0", mem_req); else passCount++;
  endtask

  task automatic test_parity;
    logic [0:35] data;
    data = 36'o525252123123;
    vma_user = 1'b1; vma = {5'h04, 8'h10, 1'b0};
    refill_req = 1'b1;
    tick;
    refill_req = 1'b0;
    tick;
    mem_ack = 1'b1; mem_data = data; mem_par = ^data;   // overall parity even: bad
    tick;
    mem_ack = 1'b0;
`ifdef PAG_REFILL_PARITY_EN
    checkCount++; if ({refill_err, pt_wr} !== 2'b10) $display("[TB] FAIL parity_err: got %b want 10", {refill_err, pt_wr}); else passCount++;
    tick;
    checkCount++; if ({refill_err, refill_done, pt_wr} !== 3'b000) $display("[TB] FAIL parity_exit: got %b want 000", {refill_err, refill_done, pt_wr}); else passCount++;
`else
    checkCount++; if ({refill_err, pt_wr} !== 2'b01) $display("[TB] FAIL parity_ignored_wr: got %b want 01", {refill_err, pt_wr}); else passCount++;
    checkCount++; if (pt_din !== 36'o525252123123) $display("[TB] FAIL parity_ignored_din: got %o want 525252123123", pt_din); else passCount++;
    tick;
    checkCount++; if (refill_done !== 1'b1) $display("[TB] FAIL parity_ignored_done: got %b want 1", refill_done); else passCount++;
`endif
    tick;
  endtask

  task automatic test_abort;
    logic seen;
    vma_user = 1'b0; vma = {5'h05, 8'h66, 1'b0};
    refill_req = 1'b1;
    tick;                               // cycle 1 ADR
    refill_req = 1'b0;
    tick;                               // cycle 2 first WAIT
    tick;                               // cycle 3 second WAIT
    abort = 1'b1; mem_ack = 1'b1; mem_data = 36'o42; mem_par = ~^36'o42;
    tick;
    abort = 1'b0; mem_ack = 1'b0;
    checkCount++; if ({mem_req, pgrf_cyc, pt_wr, refill_done} !== 4'b0000) $display("[TB] FAIL abort_outs: got %b want 0000", {mem_req, pgrf_cyc, pt_wr, refill_done}); else passCount++;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick; seen |= pt_wr | refill_done; end
    checkCount++; if (seen !== 1'b0) $display("[TB] FAIL abort_no_write: got %b want 0", seen); else passCount++;
  endtask

  task automatic test_back_to_back;
    vma_user = 1'b1; vma = {5'h06, 8'h01, 1'b0}; ubr = 13'h0AAA;
    refill_req = 1'b1;
    tick;                               // ADR
    tick;                               // WAIT
    mem_ack = 1'b1; mem_data = 36'o11; mem_par = ~^36'o11;
    tick;                               // WRITE
    mem_ack = 1'b0;
    tick;                               // DONE
    checkCount++; if (refill_done !== 1'b1) $display("[TB] FAIL b2b_done: got %b want 1", refill_done); else passCount++;
    tick;                               // IDLE, accepts again
    checkCount++; if ({mem_req, pgrf_cyc} !== 2'b00) $display("[TB] FAIL b2b_idle: got %b want 00", {mem_req, pgrf_cyc}); else passCount++;
    tick;                               // second ADR
    refill_req = 1'b0;
    checkCount++; if (mem_req !== 1'b1) $display("[TB] FAIL b2b_second_req: got %b want 1", mem_req); else passCount++;
    tick;                               // WAIT
    mem_ack = 1'b1; mem_data = 36'o22; mem_par = ~^36'o22;
    tick;                               // WRITE, abort arrives now
    mem_ack = 1'b0;
    checkCount++; if (pt_wr !== 1'b1) $display("[TB] FAIL b2b_write: got %b want 1", pt_wr); else passCount++;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checkCount++; if ({refill_done, pgrf_cyc, pt_wr} !== 3'b000) $display("[TB] FAIL b2b_abort_write: got %b want 000", {refill_done, pgrf_cyc, pt_wr}); else passCount++;
    tick;
  endtask

  initial begin
    CROBAR = 1'b1; refill_req = 1'b0; abort = 1'b0; vma_user = 1'b0;
    vma = '0; ubr = '0; ebr = '0; mem_ack = 1'b0; mem_data = '0; mem_par = 1'b0;
    test_reset;
    test_user_refill;
    test_exec_refill;
    test_ack_in_adr;
    test_timeout;
    test_parity;
    test_abort;
    test_back_to_back;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pag_refill.md
# pag_refill

Page-table refill sequencer for the KL10 MBOX: the writer end of the page table that PAG reads. When PAG reports a paged reference that missed in the page table (PAGE_REFILL), this block fetches the page-map word from physical memory through the MBOX memory port and writes both halves of the addressed page-table entry plus its directory tag. It then releases the EBOX reference for retry, or reports a refill error that PAG turns into a page fail.

## Interface
Parameters:
- TIMEOUT, default 63: maximum cycles to wait for memory acknowledge before declaring a refill error; a 6-bit counter.
- EXEC_OFS, default 1'b1: value of map-address bit 27 for exec references (user references use ~EXEC_OFS).

Ports:
- clk  in  1  MBOX clock; all state changes on rising edge
- CROBAR  in  1  synchronous active-high reset
- refill_req  in  1  PAG.PAGE_REFILL; level, sampled only in IDLE
- abort  in  1  CSH.PAGE_FAIL_HOLD or EBOX abort; cancels an in-flight refill
- vma_user  in  1  MCL.VMA_USER for the missed reference
- vma  in  [13:26]  virtual address bits of the missed reference
- ubr  in  [14:26]  user base page number
- ebr  in  [14:26]  exec base page number
- mem_req  out  1  memory read request, held until mem_ack
- mem_adr  out  [14:35]  physical address of the page-map word
- mem_ack  in  1  one-cycle data-valid strobe
- mem_data  in  [0:35]  page-map word (left half even page, right half odd page)
- mem_par  in  1  odd parity bit for mem_data
- pgrf_cyc  out  1  CSH.PGRF_CYC equivalent; high from request accept through DONE
- pt_wr  out  1  one-cycle page-table write strobe (CSH.PAGE_REFILL_T12)
- pt_adr  out  [18:26]  page-table address written
- pt_din  out  [0:35]  data written to the page table
- dir_wr  out  1  directory write strobe, coincident with pt_wr
- dir_din  out  6  {vma_user, vma[13:17]} tag written to the directory
- refill_done  out  1  one-cycle pulse: entry written, retry reference
- refill_err  out  1  CSH.PAGE_REFILL_ERROR; level, held until refill_req drops

## Operation
- States: IDLE, ADR, WAIT, WRITE, DONE, ERR.
- IDLE: on refill_req & ~abort, latch vma_user, vma[13:26], and base = vma_user ? ubr : ebr; go to ADR.
- ADR: drive mem_adr = {base[14:26], vma_user ? ~EXEC_OFS : EXEC_OFS, vma[18:25]}, which is 13+1+8 = 22 bits. Assert mem_req. Clear the timeout counter. Go to WAIT.
- WAIT: keep mem_req and mem_adr stable. On mem_ack, capture mem_data and go to WRITE, or go to ERR if parity fails (see Configuration). When the counter reaches TIMEOUT with no ack, go to ERR. Otherwise increment the counter.
- WRITE: pt_wr = dir_wr = 1 for exactly one cycle, with pt_adr = {vma[18:25], 0}. The write covers both halves, so bit 26 is irrelevant to the PT write enables. pt_din = captured word; dir_din = latched tag. Go to DONE.
- DONE: refill_done = 1 for one cycle; go to IDLE.
- ERR: refill_err = 1; no PT or directory write occurs. Stay in ERR until refill_req = 0, then go to IDLE.
- abort in ADR, WAIT, WRITE or DONE: next state is IDLE and mem_req drops. An ack arriving the same cycle as abort is discarded. If abort coincides with WRITE, the write still completes; abort is honoured after it.
- abort in ERR is ignored; ERR exits only on ~refill_req.
- pgrf_cyc = state in {ADR, WAIT, WRITE, DONE}.
- Outputs pt_adr, pt_din, dir_din and mem_adr are registered. All other outputs decode the state.

## Timing
- Reset: state IDLE; mem_req, pt_wr, dir_wr, refill_done, refill_err, pgrf_cyc = 0; mem_adr, pt_adr, pt_din, dir_din = 0; counter = 0.
- Cycle numbering from the refill_req accept edge at cycle 0:
  - ADR at cycle 1, with mem_req high.
  - With ack in cycle 1+k (k≥1), WRITE occurs at cycle 2+k and DONE at cycle 3+k.
  - Minimum request-to-done is 4 cycles.
- Timeout: ERR is entered TIMEOUT+1 cycles after WAIT entry.
- An ack in the ADR cycle is not accepted; ack is sampled only in WAIT.
- refill_req still high in the cycle after DONE starts a new refill. PAG normally deasserts it once PT_MATCH is true.

## Configuration
- PAG_REFILL_PARITY_EN defined: on mem_ack, if ^{mem_data, mem_par} = 0 (even overall parity), go to ERR instead of WRITE.
- Not defined: mem_par is ignored and every ack goes to WRITE.

## Test plan
- Reset: assert CROBAR 2 cycles mid-WAIT -> all outputs 0, state IDLE, and no pt_wr afterward even if mem_ack arrives.
- User refill: vma_user=1, vma[18:25]=8'hA5, ubr=13'h0123, EXEC_OFS=1, ack 3 cycles after mem_req with data 36'o123456_654321 and correct parity -> mem_adr={13'h0123,0,8'hA5}; pt_wr one cycle with pt_adr=9'h14A and pt_din equal to the data; refill_done 2 cycles after the ack.
- Exec refill: vma_user=0, ebr=13'h1FFF, vma[18:25]=8'hFF, immediate ack -> mem_adr bit 27 = 1, and refill_done at cycle 4.
- Timeout: TIMEOUT=63 and no ack -> refill_err rises 64 cycles after WAIT entry; pt_wr never asserts; IDLE one cycle after refill_req drops.
- Parity (macro defined): ack with wrong mem_par -> refill_err, no pt_wr. With the macro undefined, the same stimulus -> normal write and refill_done.
- Abort: abort in the 2nd WAIT cycle and ack in the same cycle -> mem_req drops next cycle, no pt_wr, no refill_done, pgrf_cyc = 0.
